// File: rtl/spi_prog_decoder.sv
// Byte-stream programming decoder: parses address-load and data-write frames
// from the SPI byte receiver and issues 32-bit writes to the memory port.
module spi_prog_decoder #(
  parameter logic [7:0] CMD_ADDR = 8'h01,
  parameter logic [7:0] CMD_DATA = 8'h02,
  parameter int unsigned ADDR_INC = 4,
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_spi_rst_n,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_valid,
  output logic             o_mem_req,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic             i_mem_ack,
  output logic             o_busy,
  output logic [2:0]       o_err,
  output logic [CNT_W-1:0] o_wr_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      sh_q, sh_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             decode_op;
  logic [31:0]      sh_next;

  assign sh_next = {sh_q[23:0], i_rx_byte};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    decode_op = 1'b0;
    case (state_q)
      S_IDLE: decode_op = i_rx_valid;
      S_ADDR, S_DATA: begin
        if (i_rx_valid) begin
          sh_d  = sh_next;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (state_q == S_ADDR) begin
              addr_d  = sh_next;
              state_d = S_IDLE;
            end else begin
              wdata_d = sh_next;
              maddr_d = addr_q;
              state_d = S_WRITE;
            end
          end
        end else if (tmo_q + TW'(1) == TMO_MAX) begin
          // Abort a stalled frame; the address register keeps its old value.
          state_d  = S_IDLE;
          err_d[2] = 1'b1;
          sh_d     = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITE: begin
        if (i_mem_ack) begin
          addr_d    = addr_q + 32'(ADDR_INC);
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d   = S_IDLE;
          decode_op = i_rx_valid;
        end else if (i_rx_valid) begin
          err_d[1] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A byte arriving with the completing ack is treated as the next opcode.
    if (decode_op) begin
      idx_d = '0;
      if (i_rx_byte == CMD_ADDR)      state_d = S_ADDR;
      else if (i_rx_byte == CMD_DATA) state_d = S_DATA;
      else begin
        state_d  = S_IDLE;
        err_d[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_spi_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_mem_req   = (state_q == S_WRITE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_mem_addr  = maddr_q;
  assign o_mem_wdata = wdata_q;
  assign o_err       = err_q;
  assign o_wr_count  = cnt_q;

endmodule

// File: doc/spi_prog_decoder.md
# spi_prog_decoder

Byte-stream command decoder between the SPI slave byte receiver and the on-chip memory write port. It parses the programming protocol used to load instruction memory (0x4000_0000 region) and the PIM buffer (0x2000_0000 region) while the core is held in reset. Opcode 0x01 is followed by a 4-byte address, MSB first. Opcode 0x02 is followed by a 4-byte data word, MSB first, and issues one 32-bit write. The address auto-increments after every completed write.

## Interface
- CMD_ADDR, 8'h01, opcode: load address register
- CMD_DATA, 8'h02, opcode: data word plus write
- ADDR_INC, 4, increment applied to address register after each acked write
- TIMEOUT, 50000, max idle cycles between bytes inside a frame before abort
- CNT_W, 16, width of write counter

- i_clk  in  1  single clock; all logic on rising edge
- i_spi_rst_n  in  1  reset, synchronous, active-low
- i_rx_byte  in  8  received byte, valid when i_rx_valid=1
- i_rx_valid  in  1  one-cycle pulse per received byte
- o_mem_req  out  1  write request, held until acked
- o_mem_addr  out  32  write address, stable while o_mem_req=1
- o_mem_wdata  out  32  write data, stable while o_mem_req=1
- i_mem_ack  in  1  write accepted; sampled only while o_mem_req=1
- o_busy  out  1  state != IDLE
- o_err  out  3  sticky: [0] bad opcode, [1] overrun, [2] timeout
- o_wr_count  out  CNT_W  completed writes, saturating

## Operation
- States: IDLE, ADDR, DATA, WRITE.
- IDLE, byte == CMD_ADDR: go to ADDR, byte index cleared.
- IDLE, byte == CMD_DATA: go to DATA, byte index cleared.
- IDLE, any other byte: set o_err[0], discard the byte, stay in IDLE.
- ADDR: shift each byte into a 32-bit shift register, MSB first (shreg = {shreg[23:0], byte}). On the 4th byte, commit {shreg[23:0], byte} to the address register, then go to IDLE. The address register is never changed by a partial frame.
- DATA: same shifting. On the 4th byte, latch o_mem_wdata, drive o_mem_addr from the address register, go to WRITE.
- WRITE: o_mem_req=1.
  - On i_mem_ack: address register += ADDR_INC (mod 2^32, wrap 0xFFFF_FFFC -> 0x0000_0000), o_wr_count += 1 (saturates at all-ones), go to IDLE.
- Overrun: i_rx_valid in WRITE without i_mem_ack in the same cycle. The byte is dropped and o_err[1] is set. o_mem_req, o_mem_addr and o_mem_wdata are unaffected.
- i_rx_valid and i_mem_ack in the same WRITE cycle: the write completes and the byte is decoded as an IDLE opcode in that same cycle. Next state is ADDR, DATA, or IDLE with o_err[0] set.
- Timeout counter:
  - Cleared on every accepted byte and in IDLE/WRITE.
  - Counts while in ADDR/DATA.
  - When it reaches TIMEOUT: go to IDLE, set o_err[2], discard the partial shift register. The address register is unchanged.
- o_err bits are cleared only by reset.

## Timing
- Reset (i_spi_rst_n=0 at a rising edge): state IDLE; o_mem_req=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_err=0, o_wr_count=0; address register=0; timeout counter=0.
- Reset asserted mid-frame or mid-WRITE aborts immediately. No write completes and no ack is counted.
- Latency: 4th data byte sampled at edge t -> o_mem_req=1 after edge t (visible in cycle t+1).
- Ack sampled at edge u -> o_mem_req=0 after edge u. The incremented address and count are visible in the same cycle.
- Ack in the first request cycle is legal: minimum request duration is 1 cycle.
- i_mem_ack while o_mem_req=0 is ignored.
- o_busy is registered with the state and goes high the cycle after the opcode byte is accepted.
- The timeout abort takes effect on the edge where the counter equals TIMEOUT, i.e. TIMEOUT cycles after the last accepted byte.

## Test plan
- Frame decode: after reset, send 01 40 00 00 00 02 00 00 00 13 with ack returned 1 cycle after req.
  -> Exactly one req with addr 0x4000_0000, wdata 0x0000_0013.
  -> o_wr_count=1, o_err=0.
- Auto-increment: continuing, send 02 DE AD BE EF, then 02 00 00 00 01.
  -> Writes at 0x4000_0004 (0xDEADBEEF) and 0x4000_0008 (0x0000_0001); o_wr_count=3.
- Bad opcode and recovery: send 7F.
  -> o_err=3'b001, no req.
  -> Then 01 20 00 00 00 02 11 22 33 44 -> write 0x1122_3344 @ 0x2000_0000.
- Timeout: set TIMEOUT=100, send 01 20 00, then idle 100 cycles.
  -> o_err[2]=1, o_busy=0.
  -> Then 02 AA BB CC DD -> write at the previous address register value, not 0x2000_xxxx partial.
- Ack stall: hold ack low 20 cycles after req and inject byte 55.
  -> o_err[1]=1; req, addr and data stable throughout.
  -> Then pulse ack in the same cycle as byte 02 -> write completes and next state is DATA (o_busy stays 1).
- Reset mid-frame: after 02 AA BB, drive i_spi_rst_n=0 for 1 cycle.
  -> All outputs 0, address register 0.
  -> Then a full frame 02 01 02 03 04 -> write 0x0102_0304 @ 0x0000_0000.
